// File: rtl/pixel_mem_responder_pkg.sv
// Shared types for the in-pixel memory model.
// Used by the cell, the interface and the top.
package pixel_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_PIX_DEF  = 4;

  localparam logic [DATA_W_DEF-1:0] SAT_CODE = '1;

  typedef enum logic [1:0] {
    EMPTY,
    ARMED,
    LATCHED
  } pix_state_t;

  // Nonzero with exactly one bit set.
  function automatic logic onehot(
    input logic [31:0] v
  );
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/pixel_mem_responder_if.sv
// Control/status bundle between array FSM and pixel memories.
// The data bus itself stays a separate inout port.
interface pixel_mem_if
  import pixel_pkg::*;
#(
  parameter int N_PIX = N_PIX_DEF
);

  logic             erase;
  logic             expose;
  logic             convert;
  logic [N_PIX-1:0] read;
  logic [N_PIX-1:0] cmp_trip;
  logic [N_PIX-1:0] pix_valid;
  logic [N_PIX-1:0] pix_ovf;
  logic             bus_conflict;

  modport master (
    output erase,
    output expose,
    output convert,
    output read,
    output cmp_trip,
    input  pix_valid,
    input  pix_ovf,
    input  bus_conflict
  );

  modport slave (
    input  erase,
    input  expose,
    input  convert,
    input  read,
    input  cmp_trip,
    output pix_valid,
    output pix_ovf,
    output bus_conflict
  );

endinterface

// File: rtl/pixel_mem_responder_cell.sv
// One pixel memory: EMPTY/ARMED/LATCHED FSM and stored code.
// TRIP_DEGLITCH_EN adds a one-deep holding register per pixel.
module pixel_mem_cell
  import pixel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              convert,
  input  logic              trip,
  input  logic [DATA_W-1:0] bus_d,
  output logic [DATA_W-1:0] mem,
  output logic              valid,
  output logic              ovf
);

  pix_state_t        state, state_n;
  logic [DATA_W-1:0] mem_n;
  logic              valid_n;
  logic              ovf_n;

`ifdef TRIP_DEGLITCH_EN
  logic [DATA_W-1:0] hold, hold_n;
  logic              pend, pend_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      pend <= 1'b0;
    end else begin
      hold <= hold_n;
      pend <= pend_n;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      mem   <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      mem   <= mem_n;
      valid <= valid_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    mem_n   = mem;
    valid_n = valid;
    ovf_n   = ovf;
`ifdef TRIP_DEGLITCH_EN
    hold_n  = hold;
    pend_n  = pend;
`endif
    if (erase) begin
      state_n = EMPTY;
      mem_n   = '0;
      valid_n = 1'b0;
      ovf_n   = 1'b0;
`ifdef TRIP_DEGLITCH_EN
      pend_n  = 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (convert) begin
            state_n = ARMED;
`ifdef TRIP_DEGLITCH_EN
            if (trip) begin
              hold_n = bus_d;
              pend_n = 1'b1;
            end
`else
            if (trip) begin
              mem_n   = bus_d;
              valid_n = 1'b1;
              state_n = LATCHED;
            end
`endif
          end
        end
        ARMED: begin
          if (!convert) begin
            // Ramp ended without a (confirmed) trip.
            mem_n   = {DATA_W{1'b1}};
            valid_n = 1'b1;
            ovf_n   = 1'b1;
            state_n = LATCHED;
`ifdef TRIP_DEGLITCH_EN
            pend_n  = 1'b0;
`endif
          end else begin
`ifdef TRIP_DEGLITCH_EN
            if (trip && pend) begin
              mem_n   = hold;
              valid_n = 1'b1;
              state_n = LATCHED;
              pend_n  = 1'b0;
            end else if (trip) begin
              hold_n = bus_d;
              pend_n = 1'b1;
            end else begin
              pend_n = 1'b0;
            end
`else
            if (trip) begin
              mem_n   = bus_d;
              valid_n = 1'b1;
              state_n = LATCHED;
            end
`endif
          end
        end
        LATCHED: begin
          state_n = LATCHED;
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/pixel_mem_responder.sv
// Pixel-side end of the shared tri-state pixel data bus.
// Optional macro: TRIP_DEGLITCH_EN (two-edge trip confirmation).
module pixel_mem_responder
  import pixel_pkg::*;
#(
  parameter int N_PIX  = N_PIX_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  pixel_mem_if.slave        bus,
  inout  wire  [DATA_W-1:0] pix_data
);

  logic [DATA_W-1:0] mem [N_PIX];
  logic [DATA_W-1:0] bus_d;
  logic [DATA_W-1:0] drive_val;
  logic              rd_any;
  logic              rd_one;
  logic              drive_en;
  logic              bad_rd;
  logic              conflict_q;

  assign bus_d = pix_data;

  // Comparators are meaningless while the pixel integrates.
  for (genvar i = 0; i < N_PIX; i++) begin : g_cell
    pixel_mem_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .erase   (bus.erase),
      .convert (bus.convert),
      .trip    (bus.cmp_trip[i] & ~bus.expose),
      .bus_d   (bus_d),
      .mem     (mem[i]),
      .valid   (bus.pix_valid[i]),
      .ovf     (bus.pix_ovf[i])
    );
  end

  assign rd_any   = |bus.read;
  assign rd_one   = onehot(32'(bus.read));
  assign drive_en = rd_one && !bus.convert;
  assign bad_rd   = rd_any && (!rd_one || bus.convert);

  always_comb begin
    drive_val = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (bus.read[i]) begin
        drive_val = mem[i];
      end
    end
  end

  assign pix_data = drive_en ? drive_val : 'z;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 1'b0;
    end else if (bad_rd) begin
      conflict_q <= 1'b1;
    end
  end

  assign bus.bus_conflict = conflict_q;

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Scoreboard bench for pixel_mem_responder.
// Expected values follow TRIP_DEGLITCH_EN when defined.
module tb_pixel_mem_responder;
  import pixel_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;

`ifdef TRIP_DEGLITCH_EN
  localparam bit DG = 1'b1;
`else
  localparam bit DG = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [DW-1:0] tb_bus;
  logic          tb_drv;
  wire  [DW-1:0] pix_data;

  int errors;
  int checks;
  int exp_q [$];

  pixel_mem_if #(.N_PIX(NP)) pif ();

  pixel_mem_responder #(
    .N_PIX  (NP),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (pif),
    .pix_data (pix_data)
  );

  assign pix_data = tb_drv ? tb_bus : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    pif.erase    = 1'b0;
    pif.expose   = 1'b0;
    pif.convert  = 1'b0;
    pif.read     = '0;
    pif.cmp_trip = '0;
    tb_drv       = 1'b0;
    tb_bus       = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_erase();
    @(negedge clk);
    pif.erase = 1'b1;
    @(negedge clk);
    pif.erase = 1'b0;
  endtask

  // Full 0..255 ramp; pixel i trips from code[i], 256 = never.
  task automatic ramp(
    input int code [NP],
    input int pulse
  );
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      tb_drv      = 1'b1;
      tb_bus      = DW'(c);
      pif.convert = 1'b1;
      for (int i = 0; i < NP; i++) begin
        pif.cmp_trip[i] = (c >= code[i]) ||
                          (i == 0 && c == pulse);
      end
    end
    @(negedge clk);
    pif.convert  = 1'b0;
    pif.cmp_trip = '0;
    tb_drv       = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_pix(
    input string tag,
    input int    i,
    input int    exp
  );
    int e;
    @(negedge clk);
    pif.read = NP'(1 << i);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, 32'(pix_data), 32'(e));
    @(negedge clk);
    pif.read = '0;
  endtask

  initial begin
    int c;
    logic rel;
    errors = 0;
    checks = 0;
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(pif.pix_valid), 0);
    chk("rst_ovf", 32'(pif.pix_ovf), 0);
    chk("rst_conf", 32'(pif.bus_conflict), 0);
    reset = 1'b1;

    do_erase();
    ramp('{10, 50, 200, 255}, -1);
    read_pix("rd_p0", 0, 10);
    read_pix("rd_p1", 1, 50);
    read_pix("rd_p2", 2, 200);
    read_pix("rd_p3", 3, 255);
    chk("t1_valid", 32'(pif.pix_valid), 32'hf);
    chk("t1_ovf", 32'(pif.pix_ovf), DG ? 32'h8 : 32'h0);

    do_erase();
    ramp('{10, 50, 256, 100}, -1);
    read_pix("rd_sat", 2, 255);
    chk("t2_ovf", 32'(pif.pix_ovf), 32'h4);

    @(negedge clk);
    pif.read = 4'b0011;
    #1;
    rel = (pix_data === 8'hzz) || (pix_data == 8'h00);
    chk("multi_rel", 32'(rel), 1);
    @(posedge clk);
    #1;
    chk("multi_conf", 32'(pif.bus_conflict), 1);
    @(negedge clk);
    pif.read = '0;
    @(posedge clk);
    #1;
    chk("conf_sticky", 32'(pif.bus_conflict), 1);
    do_reset();
    #1;
    chk("conf_clr", 32'(pif.bus_conflict), 0);
    @(negedge clk);
    pif.convert = 1'b1;
    pif.read    = 4'b0001;
    @(posedge clk);
    #1;
    chk("conv_conf", 32'(pif.bus_conflict), 1);
    @(negedge clk);
    idle();
    do_reset();

    do_erase();
    ramp('{256, 37, 256, 256}, -1);
    read_pix("first37", 1, 37);
    ramp('{256, 90, 256, 256}, -1);
    read_pix("no_erase", 1, 37);
    do_erase();
    ramp('{256, 90, 256, 256}, -1);
    read_pix("re_conv", 1, 90);

    do_erase();
    c = 0;
    while (c <= 25) begin
      @(negedge clk);
      tb_drv          = 1'b1;
      tb_bus          = DW'(c);
      pif.convert     = 1'b1;
      pif.cmp_trip[0] = (c >= 20);
      c++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(pif.pix_valid), 0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    read_pix("mid_rst_rd", 0, 0);

    do_erase();
    ramp('{60, 256, 256, 256}, 30);
    read_pix("deglitch", 0, DG ? 60 : 30);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule

// File: doc/pixel_mem_responder.md
Name: pixel_mem_responder

Overview:
- Digital model of the in-pixel memory: the pixel-side end of the shared tri-state pixel data bus.
- During convert, the ramp-ADC counter drives the bus. Each pixel's comparator trip latches the current counter code into that pixel's memory.
- During readout, the pixel whose read strobe is active drives its stored code back onto the same bus, where the array controller captures it.
- Sits beside the analog pixel array and is controlled by the same erase/expose/convert/read FSM outputs.

Parameters:
- N_PIX, 4, number of pixel memories (one read strobe each)
- DATA_W, 8, counter/bus width in bits

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- erase  input  1  clear all pixel memories
- expose  input  1  exposure phase (memories hold; no capture)
- convert  input  1  ramp conversion phase; bus carries counter code
- read  input  N_PIX  one-hot read strobes, bit i selects pixel i
- cmp_trip  input  N_PIX  comparator outputs; high once the ramp has crossed the pixel voltage
- pix_data  inout  DATA_W  shared tri-state bus; sampled during convert, driven during read
- pix_valid  output  N_PIX  pixel i holds a code from the current conversion
- pix_ovf  output  N_PIX  pixel i never tripped; stored code is saturated
- bus_conflict  output  1  sticky; illegal read/convert combination seen

Behaviour:
- Reset (reset=0, async): all memories 0, all pixels EMPTY; pix_valid=0, pix_ovf=0, bus_conflict=0; pix_data released (Z).
- Per-pixel states: EMPTY, ARMED, LATCHED. All transitions occur at posedge clk.
  - Any state, erase=1: mem<=0, valid<=0, ovf<=0 -> EMPTY. erase has priority over all other inputs.
  - EMPTY, convert=1: -> ARMED. Capture is allowed in this same cycle, so a trip seen on the first convert edge stores the code then present on pix_data (0).
  - ARMED, convert=1 and cmp_trip[i]=1: mem<=pix_data sampled at that edge, valid<=1 -> LATCHED. There is zero extra latency: the stored code is the counter value before that edge's increment.
  - ARMED, convert falls with no trip: mem<={DATA_W{1'b1}}, valid<=1, ovf<=1 -> LATCHED.
  - LATCHED: holds through convert, expose and read. A new conversion requires erase first; convert in LATCHED is ignored.
- Bus drive is combinational:
  - pix_data = mem[i] exactly when read==(1<<i) and convert=0. Otherwise pix_data is Z.
  - The read strobe must be stable for the controller's sampling edge. The driven value is independent of state (an EMPTY pixel drives 0).
- Conflicts:
  - More than one read bit high: nothing drives, bus_conflict<=1.
  - Any read bit with convert=1: nothing drives, bus_conflict<=1.
  - bus_conflict clears only on reset.
- Reset mid-conversion discards all partial captures. cmp_trip is ignored outside convert.
- Simultaneous trips across pixels are independent: every tripping pixel latches the same code.

Optional Feature:
- Macro TRIP_DEGLITCH_EN.
- When defined:
  - cmp_trip[i] must be high on two consecutive convert edges to latch.
  - The stored code is the value sampled at the first of the two edges, held in a one-deep per-pixel holding register.
  - A single-cycle pulse is discarded and the pixel stays ARMED.
  - If convert falls between the two edges, the pixel saturates as in the no-trip case.
- When undefined: single-edge capture as above; no holding register.

Decomposition:
- Package pixel_pkg:
  - typedef enum pix_state_t {EMPTY, ARMED, LATCHED}
  - localparam DATA_W_DEF=8, N_PIX_DEF=4
  - SAT_CODE (all ones)
- Sub-module pixel_mem_cell: one pixel's FSM, memory, optional deglitch register and drive request. Instantiated N_PIX times by generate.
- Top level owns the read one-hot check, the bus tri-state and bus_conflict.

Test Plan:
- Reset then erase, convert counter 0..255 on bus, trips at codes 10/50/200/255 on pixels 0..3; read each in turn -> bus reads 10, 50, 200, 255; pix_valid=4'b1111, pix_ovf=0.
- Convert full ramp with cmp_trip[2] never high; read pixel 2 -> 255, pix_ovf[2]=1, others 0.
- read=4'b0011 for one cycle -> pix_data all Z, bus_conflict=1 and still 1 after read=0; reset -> 0.
- Pixel 1 latched at 37, second convert without erase, trip at 90 -> read returns 37; after erase, convert, trip at 90 -> 90.
- Drop reset mid-convert after pixel 0 latched at 20 -> pix_valid=0; read pixel 0 after release -> 0.
- TRIP_DEGLITCH_EN: 1-cycle pulse at code 30 then steady high from code 60 -> stores 60. Undefined, same stimulus -> stores 30.
